// File: rtl/divider_control.sv
// Sequencing FSM for the restoring divider: turns one Run rising edge into the
// INIT, ITER x ITERS, FIX, DONE sequence that drives the Remainder register and ALU.
module divider_control #(
  parameter int ITERS = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Run,
  output logic             Rem_init,
  output logic             W_ctrl,
  output logic             SLL_ctrl,
  output logic             SRL_ctrl,
  output logic             Ready,
  output logic             ALU_ctrl,
  output logic             Busy,
  output logic [CNT_W-1:0] Count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  typedef struct packed {
    logic rem_init;
    logic w;
    logic sll;
    logic srl;
    logic ready;
    logic alu;
    logic busy;
  } ctrl_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  // Outputs are decoded from the next state and registered, so the registered
  // outputs always describe the state the FSM is currently in.
  function automatic ctrl_t decode(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_INIT: begin
        c.rem_init = 1'b1;
        c.w        = 1'b1;
        c.sll      = 1'b1;
        c.busy     = 1'b1;
      end
      S_ITER: begin
        c.w    = 1'b1;
        c.sll  = 1'b1;
        c.alu  = 1'b1;
        c.busy = 1'b1;
      end
      S_FIX: begin
        c.srl  = 1'b1;
        c.busy = 1'b1;
      end
      S_DONE:  c.ready = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             run_q, run_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             start;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    start   = Run & ~run_q;
    run_d   = Run;
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          count_d = '0;
        end
      end
      S_INIT: begin
        state_d = S_ITER;
        count_d = '0;
      end
      S_ITER: begin
        if (count_q == LAST_CNT) state_d = S_FIX;
        else                     count_d = count_q + 1'b1;
      end
      S_FIX:  state_d = S_DONE;
      S_DONE: begin
        // Restart clears Count on entry to INIT; otherwise hold Ready.
        if (start) begin
          state_d = S_INIT;
          count_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ctrl_d = decode(state_d);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      run_q   <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      run_q   <= run_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign Rem_init = ctrl_q.rem_init;
  assign W_ctrl   = ctrl_q.w;
  assign SLL_ctrl = ctrl_q.sll;
  assign SRL_ctrl = ctrl_q.srl;
  assign Ready    = ctrl_q.ready;
  assign ALU_ctrl = ctrl_q.alu;
  assign Busy     = ctrl_q.busy;
  assign Count    = count_q;

endmodule

// File: doc/divider_control.md
Name: divider_control

Overview:
- Sequencing FSM for the sequential restoring divider. It drives the control inputs of the Remainder register: the init strobe wired to the register's Reset port, W_ctrl, SLL_ctrl, SRL_ctrl and Ready.
- It also drives the ALU operation select.
- It sits between the top-level divider wrapper (Run request) and the Remainder register and ALU.
- It turns one Run request into the full init, iterate, fix-up, done sequence.

Parameters:
- ITERS, 32: number of shift/subtract iterations. Equals dividend width.
- CNT_W, 6: counter width. Must satisfy 2^CNT_W > ITERS.

Ports:
- clk  input  1  system clock, rising-edge.
- Reset  input  1  synchronous, active-high controller reset.
- Run  input  1  start request. Only a rising edge is acted on.
- Rem_init  output  1  drives the Remainder Reset/load port. Loads Dividend_in<<1 into the low half and clears the high half.
- W_ctrl  output  1  Remainder write enable for the ALU_result / carry update.
- SLL_ctrl  output  1  Remainder shift-left-by-1 enable.
- SRL_ctrl  output  1  Remainder high-half shift-right-by-1 enable (final fix-up).
- Ready  output  1  division complete. The Remainder holds its value while Ready=1.
- ALU_ctrl  output  1  1 = subtract (Remainder_hi - Divisor), 0 = idle/pass.
- Busy  output  1  1 from INIT through FIX inclusive.
- Count  output  CNT_W  current iteration index, for debug and verification.

Behaviour:
- All state and outputs are registered. Outputs are a Moore decode of the registered state; no output depends combinationally on Run.
- Reset=1 at a rising edge: state=IDLE, Count=0, Run_d=0. All outputs are 0 from that edge on. Reset has priority over every other event, including mid-operation. There is no partial completion and Ready does not assert.
- Start detection: start = Run & ~Run_d. Run_d is Run registered every cycle, cleared by Reset.
- States and outputs:
  - IDLE: all outputs 0.
  - INIT: Rem_init=1, W_ctrl=1, SLL_ctrl=1, Busy=1.
  - ITER: W_ctrl=1, SLL_ctrl=1, ALU_ctrl=1, Busy=1.
  - FIX: SRL_ctrl=1, Busy=1, SLL_ctrl=0, W_ctrl=0.
  - DONE: Ready=1, all other controls 0.
- Transitions:
  - IDLE -> INIT on start; otherwise stay in IDLE.
  - INIT -> ITER unconditionally; Count<=0.
  - ITER: if Count==ITERS-1, go to FIX; otherwise Count<=Count+1 and stay in ITER.
  - FIX -> DONE unconditionally.
  - DONE -> INIT on start; otherwise stay in DONE with Ready held high.
- Latency: if start is sampled at edge k, the state is INIT after edge k and ITER after edge k+1. There are exactly ITERS ITER cycles. The state is FIX after edge k+ITERS+1 and DONE (Ready=1) after edge k+ITERS+2, i.e. edge k+34 for the default.
- Run held high continuously produces exactly one operation. A new operation requires Run to be seen low for at least one cycle, then high.
- A start edge during INIT, ITER or FIX is ignored; Busy stays 1 and there is no restart.
- SLL_ctrl and SRL_ctrl are never both 1 in the same cycle.
- Rem_init is 1 only in INIT.
- Count stays at ITERS-1 through FIX and DONE, and is cleared to 0 on the next INIT.
- Divide-by-zero is not detected here. The sequence runs identically and is flagged by the wrapper.

Test Plan:
- Reset at time 0, Run=0 for 5 cycles: all outputs 0, Count=0.
- Single Run pulse:
  - Rem_init=1 for exactly 1 cycle.
  - W_ctrl=SLL_ctrl=ALU_ctrl=1 for exactly 32 cycles, with Count stepping 0..31.
  - SRL_ctrl=1 for 1 cycle.
  - Ready=1 at edge k+34 and held for 10 further cycles.
- Run held high for 50 cycles: one complete sequence only; Ready stays 1 and there is no second Rem_init.
- Run pulse, then second Run pulse at ITER Count=10: ignored; Ready still at edge k+34.
- Reset=1 during ITER at Count=20: next edge all outputs 0 and state IDLE. A subsequent Run gives a full 34-cycle sequence.
- From DONE, Run low 1 cycle then high: Ready drops and Rem_init=1 on the next cycle. Repeat with dividend 0xFFFF_FFFF / divisor 10 in the integrated bench: quotient 0x1999_9999, remainder 5.
